// File: rtl/seq_pattern_monitor_pkg.sv
// ---------------------------------------------------------------------------
// seqmon_pkg
// Shared types for the serial sequence pattern monitor.
//   seqmon_state_t : lock FSM state encoding
//   DEFAULT_PAT_W  : default pattern/window width
// ---------------------------------------------------------------------------
package seqmon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } seqmon_state_t;

  localparam int DEFAULT_PAT_W = 4;

endpackage : seqmon_pkg

// File: rtl/seq_pattern_monitor_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_monitor_if
// Bundles the serial input, control and status signals of the monitor.
//   master : bit source / observer (drives bit_in, bit_valid, pat_en, pattern)
//   slave  : the monitor (drives match, match_count, interval, locked, lost)
// Optional macro SEQMON_STICKY_ERR_EN adds err_sticky (monitor -> master).
// ---------------------------------------------------------------------------
interface seq_pattern_monitor_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) ();

  logic             bit_in;
  logic             bit_valid;
  logic             pat_en;
  logic [PAT_W-1:0] pattern;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] interval;
  logic             locked;
  logic             lost;
`ifdef SEQMON_STICKY_ERR_EN
  logic             err_sticky;

  modport master (
    output bit_in, bit_valid, pat_en, pattern,
    input  match, match_count, interval, locked, lost, err_sticky
  );

  modport slave (
    input  bit_in, bit_valid, pat_en, pattern,
    output match, match_count, interval, locked, lost, err_sticky
  );
`else
  modport master (
    output bit_in, bit_valid, pat_en, pattern,
    input  match, match_count, interval, locked, lost
  );

  modport slave (
    input  bit_in, bit_valid, pat_en, pattern,
    output match, match_count, interval, locked, lost
  );
`endif

endinterface : seq_pattern_monitor_if

// File: rtl/seq_pattern_monitor_matcher.sv
// ---------------------------------------------------------------------------
// pattern_shift_matcher
// Serial window shift register, fill counter and pattern comparator.
//   clk, reset : clock, async active-high reset
//   en         : 0 = synchronous clear of window and fill
//   bit_in     : serial bit, shifted in when bit_valid=1
//   bit_valid  : qualifies bit_in
//   pat_q      : pattern to compare against (MSB = oldest bit)
//   hit        : combinational; the bit being sampled completes the pattern
// ---------------------------------------------------------------------------
module pattern_shift_matcher #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [PAT_W-1:0] pat_q,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  sr_r;
  logic [FILL_W-1:0] fill_r;
  logic [PAT_W-1:0]  nxt_s;

  // Window contents including the bit currently being sampled.
  assign nxt_s = {sr_r[PAT_W-2:0], bit_in};

  // The sampled bit completes the pattern once PAT_W-1 older bits are held.
  assign hit = en && bit_valid && (fill_r >= FILL_HIT) && (nxt_s == pat_q);

  // Window shift register and saturating fill counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_r   <= {PAT_W{1'b0}};
      fill_r <= FILL_ZERO;
    end else if (!en) begin
      sr_r   <= {PAT_W{1'b0}};
      fill_r <= FILL_ZERO;
    end else if (bit_valid) begin
      sr_r   <= nxt_s;
      fill_r <= (fill_r == FILL_FULL) ? FILL_FULL : fill_r + FILL_ONE;
    end else begin
      sr_r   <= sr_r;
      fill_r <= fill_r;
    end
  end

endmodule : pattern_shift_matcher

// File: rtl/seq_pattern_monitor.sv
// ---------------------------------------------------------------------------
// seq_pattern_monitor
// Detects a programmable PAT_W-bit pattern in a serial stream (overlapping
// matches allowed), counts matches, measures match spacing and runs a lock
// FSM that declares the stream periodic and flags loss of lock.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : seq_pattern_monitor_if.slave
//            in : bit_in, bit_valid, pat_en, pattern
//            out: match, match_count, interval, locked, lost
// Optional macro SEQMON_STICKY_ERR_EN adds bus.err_sticky, set whenever lost
// pulses and cleared only by reset or pat_en=0.
// ---------------------------------------------------------------------------
module seq_pattern_monitor
  import seqmon_pkg::*;
#(
  parameter int PAT_W     = DEFAULT_PAT_W,
  parameter int CNT_W     = 8,
  parameter int LOCK_HITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_pattern_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_HITS);

  seqmon_state_t    state_r, state_s;
  logic [PAT_W-1:0] pat_q_r, pat_q_s;
  logic [CNT_W-1:0] sp_cnt_r, sp_cnt_s;
  logic [CNT_W-1:0] ref_r, ref_s;
  logic [CNT_W-1:0] hits_r, hits_s, hits_new_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CNT_W-1:0] interval_r, interval_s;
  logic [CNT_W-1:0] sp_s;
  logic             match_r, match_s;
  logic             locked_r;
  logic             lost_r, lost_s;
  logic             hit_s;

  pattern_shift_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.pat_en),
    .bit_in    (bus.bit_in),
    .bit_valid (bus.bit_valid),
    .pat_q     (pat_q_r),
    .hit       (hit_s)
  );

  // Spacing including the bit being sampled, saturating at all-ones.
  assign sp_s = (sp_cnt_r == CNT_MAX) ? CNT_MAX : sp_cnt_r + CNT_ONE;

  // Next-state, counter and output computation.
  always_comb begin
    state_s    = state_r;
    pat_q_s    = pat_q_r;
    sp_cnt_s   = sp_cnt_r;
    ref_s      = ref_r;
    hits_s     = hits_r;
    hits_new_s = hits_r;
    count_s    = count_r;
    interval_s = interval_r;
    match_s    = 1'b0;
    lost_s     = 1'b0;
    if (!bus.pat_en) begin
      // Clear takes priority over any hit on the same edge.
      state_s    = IDLE;
      sp_cnt_s   = CNT_ZERO;
      ref_s      = CNT_ZERO;
      hits_s     = CNT_ZERO;
      count_s    = CNT_ZERO;
      interval_s = CNT_ZERO;
    end else begin
      if (hit_s) begin
        match_s    = 1'b1;
        count_s    = (count_r == CNT_MAX) ? CNT_MAX : count_r + CNT_ONE;
        interval_s = sp_s;
        sp_cnt_s   = CNT_ZERO;
      end else if (bus.bit_valid) begin
        sp_cnt_s   = sp_s;
      end else begin
        sp_cnt_s   = sp_cnt_r;
      end

      case (state_r)
        IDLE: begin
          state_s = SEARCH;
          pat_q_s = bus.pattern;
        end
        SEARCH: begin
          if (hit_s) begin
            state_s = TRACK;
            hits_s  = CNT_ZERO;
          end else begin
            state_s = SEARCH;
          end
        end
        TRACK: begin
          if (hit_s) begin
            // A new spacing restarts the run; an equal one extends it.
            if ((hits_r == CNT_ZERO) || (sp_s != ref_r)) begin
              ref_s      = sp_s;
              hits_new_s = CNT_ONE;
            end else begin
              hits_new_s = hits_r + CNT_ONE;
            end
            hits_s = hits_new_s;
            if (hits_new_s == LOCK_TGT) begin
              state_s = LOCKED;
            end else begin
              state_s = TRACK;
            end
          end else begin
            state_s = TRACK;
          end
        end
        LOCKED: begin
          // Lock is lost on a mis-spaced match or on a missed expected match.
          if ((hit_s && (sp_s != ref_r)) ||
              (bus.bit_valid && !hit_s && (sp_s == ref_r))) begin
            state_s = SEARCH;
            hits_s  = CNT_ZERO;
            lost_s  = 1'b1;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pat_q_r    <= {PAT_W{1'b0}};
      sp_cnt_r   <= CNT_ZERO;
      ref_r      <= CNT_ZERO;
      hits_r     <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      interval_r <= CNT_ZERO;
      match_r    <= 1'b0;
      locked_r   <= 1'b0;
      lost_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pat_q_r    <= pat_q_s;
      sp_cnt_r   <= sp_cnt_s;
      ref_r      <= ref_s;
      hits_r     <= hits_s;
      count_r    <= count_s;
      interval_r <= interval_s;
      match_r    <= match_s;
      locked_r   <= (state_s == LOCKED);
      lost_r     <= lost_s;
    end
  end

  assign bus.match       = match_r;
  assign bus.match_count = count_r;
  assign bus.interval    = interval_r;
  assign bus.locked      = locked_r;
  assign bus.lost        = lost_r;

`ifdef SEQMON_STICKY_ERR_EN
  logic err_r, err_s;

  // Sticky loss-of-lock flag.
  always_comb begin
    err_s = err_r;
    if (!bus.pat_en) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r | lost_s;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign bus.err_sticky = err_r;
`endif

endmodule : seq_pattern_monitor

// File: tb/tb_seq_pattern_monitor.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_monitor
// Directed bench for seq_pattern_monitor: one instance with CNT_W=8 and one
// with CNT_W=4 (saturation), both fed the same stimulus.
// Honours SEQMON_STICKY_ERR_EN for the err_sticky output.
// ---------------------------------------------------------------------------
module tb_seq_pattern_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       pat_en = 1'b0;
  logic [3:0] pattern = 4'b0101;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_monitor_if #(.PAT_W(4), .CNT_W(8)) bus ();
  seq_pattern_monitor_if #(.PAT_W(4), .CNT_W(4)) bus4 ();

  assign bus.bit_in     = bit_in;
  assign bus.bit_valid  = bit_valid;
  assign bus.pat_en     = pat_en;
  assign bus.pattern    = pattern;
  assign bus4.bit_in    = bit_in;
  assign bus4.bit_valid = bit_valid;
  assign bus4.pat_en    = pat_en;
  assign bus4.pattern   = pattern;

  seq_pattern_monitor #(.PAT_W(4), .CNT_W(8), .LOCK_HITS(3)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  seq_pattern_monitor #(.PAT_W(4), .CNT_W(4), .LOCK_HITS(3)) dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_sticky(input string tag, input logic exp);
`ifdef SEQMON_STICKY_ERR_EN
    check_eq(tag, {31'd0, bus.err_sticky}, {31'd0, exp});
`else
    if (exp === 1'bx) checks = checks + 0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_match"},    {31'd0, bus.match},       32'd0);
    check_eq({tag, "_count"},    {24'd0, bus.match_count}, 32'd0);
    check_eq({tag, "_interval"}, {24'd0, bus.interval},    32'd0);
    check_eq({tag, "_locked"},   {31'd0, bus.locked},      32'd0);
    check_eq({tag, "_lost"},     {31'd0, bus.lost},        32'd0);
    check_eq({tag, "_count4"},   {28'd0, bus4.match_count}, 32'd0);
    check_sticky({tag, "_sticky"}, 1'b0);
  endtask

  // One clock edge with the given inputs, then sample 1 time unit later.
  task automatic step(input logic b, input logic v);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Clean 0,1,0,1,... stream from a cleared monitor with pattern 0101.
  // Hits on even bits k>=4; hit count = k/2-1; locked from bit 10 on.
  task automatic run_clean(input int nbits, input bit gap);
    int   exp_cnt;
    logic eb;
    for (int k = 1; k <= nbits; k++) begin
      eb = (k % 2 == 0);
      step(eb, 1'b1);
      exp_cnt = (k >= 4) ? (k / 2 - 1) : 0;
      check_eq("match",  {31'd0, bus.match},        {31'd0, (k >= 4) && eb});
      check_eq("count",  {24'd0, bus.match_count},  exp_cnt);
      check_eq("count4", {28'd0, bus4.match_count}, (exp_cnt > 15) ? 15 : exp_cnt);
      check_eq("locked", {31'd0, bus.locked},       {31'd0, k >= 10});
      check_eq("lost",   {31'd0, bus.lost},         32'd0);
      if (k >= 6) check_eq("interval", {24'd0, bus.interval}, 32'd2);
      if (gap) begin
        step(~eb, 1'b0);
        check_eq("gap_match",  {31'd0, bus.match},       32'd0);
        check_eq("gap_count",  {24'd0, bus.match_count}, exp_cnt);
        check_eq("gap_locked", {31'd0, bus.locked},      {31'd0, k >= 10});
      end
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #6;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: lock on the clean stream
    pattern = 4'b0101;
    pat_en  = 1'b1;
    run_clean(10, 1'b0);

    // Scenario 2: bit 12 forced to 0 -> lock lost, then relock
    step(1'b0, 1'b1);  // bit 11
    check_eq("s2_b11_locked", {31'd0, bus.locked}, 32'd1);
    check_eq("s2_b11_lost",   {31'd0, bus.lost},   32'd0);
    step(1'b0, 1'b1);  // bit 12 forced
    check_eq("s2_b12_match",  {31'd0, bus.match},  32'd0);
    check_eq("s2_b12_lost",   {31'd0, bus.lost},   32'd1);
    check_eq("s2_b12_locked", {31'd0, bus.locked}, 32'd0);
    check_eq("s2_b12_count",  {24'd0, bus.match_count}, 32'd4);
    check_sticky("s2_b12_sticky", 1'b1);
    for (int k = 13; k <= 22; k++) begin
      step((k % 2 == 0), 1'b1);
      check_eq("s2_match",  {31'd0, bus.match},  {31'd0, (k >= 16) && (k % 2 == 0)});
      check_eq("s2_lost",   {31'd0, bus.lost},   32'd0);
      check_eq("s2_locked", {31'd0, bus.locked}, {31'd0, k >= 22});
      if (k == 16) check_eq("s2_interval16", {24'd0, bus.interval}, 32'd6);
      if (k == 18) check_eq("s2_interval18", {24'd0, bus.interval}, 32'd2);
    end
    check_eq("s2_count",  {24'd0, bus.match_count},  32'd8);
    check_eq("s2_count4", {28'd0, bus4.match_count}, 32'd8);
    check_sticky("s2_sticky_held", 1'b1);

    // Scenario 5: pattern change while locked is ignored
    pattern = 4'b1111;
    step(1'b0, 1'b1);  // bit 23
    check_eq("s5_b23_locked", {31'd0, bus.locked}, 32'd1);
    step(1'b1, 1'b1);  // bit 24
    check_eq("s5_b24_match",  {31'd0, bus.match},  32'd1);
    check_eq("s5_b24_count",  {24'd0, bus.match_count}, 32'd9);
    check_eq("s5_b24_locked", {31'd0, bus.locked}, 32'd1);
    step(1'b0, 1'b1);  // bit 25
    // Clear on the same edge as a completing bit: clear wins
    pat_en = 1'b0;
    step(1'b1, 1'b1);  // bit 26
    check_all_zero("s5_clear");
    pat_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step((k % 2 == 0), 1'b1);
      check_eq("s5_nomatch", {31'd0, bus.match}, 32'd0);
    end
    check_eq("s5_count",  {24'd0, bus.match_count}, 32'd0);
    check_eq("s5_locked", {31'd0, bus.locked},      32'd0);

    // Scenario 4: bit_valid low every other cycle
    pattern = 4'b0101;
    pat_en  = 1'b0;
    step(1'b0, 1'b0);
    check_all_zero("s4_clear");
    pat_en = 1'b1;
    run_clean(10, 1'b1);

    // Scenario 6: async reset mid-TRACK, then clean rerun (covers saturation)
    pat_en = 1'b0;
    step(1'b0, 1'b0);
    pat_en = 1'b1;
    run_clean(7, 1'b0);
    check_eq("s6_pre_count", {24'd0, bus.match_count}, 32'd2);
    #3 rst = 1'b1;
    #1;
    check_all_zero("s6_async");
    @(posedge clk);
    #1;
    check_all_zero("s6_held");
    @(negedge clk);
    rst = 1'b0;
    run_clean(40, 1'b0);
    check_eq("s3_count8_final", {24'd0, bus.match_count},  32'd19);
    check_eq("s3_count4_final", {28'd0, bus4.match_count}, 32'd15);
    check_sticky("s6_sticky", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_pattern_monitor
